sysid_reader: RTL and testbench
===============================

# sysid_reader

Avalon-MM read master that fetches the two words of the system-ID slave: word 0 is the ID and word 1 is the build timestamp. It compares both words against expected values and reports pass/fail and timeout status. It sits beside the camera-control logic and lets hardware gate pipeline start-up on a matching bitstream identity, without Nios software involvement.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_0000, ID value that counts as a match
- EXPECTED_TS, 32'h0000_0000, timestamp value that counts as a match
- TIMEOUT, 255, maximum cycles per read transaction (request plus response); range 2..65535
- AUTO_START, 1, when 1 a read sequence launches in the first cycle after reset deasserts

Ports:
- clock, in, 1, single system clock; all logic on its rising edge
- reset, in, 1, synchronous active-high reset
- start, in, 1, single-cycle request to run a read sequence
- av_address, out, 1, slave word address: 0 = ID, 1 = timestamp
- av_read, out, 1, read strobe
- av_waitrequest, in, 1, slave stall
- av_readdata, in, 32, slave read data
- av_readdatavalid, in, 1, read data qualifier
- busy, out, 1, sequence in progress
- done, out, 1, one-cycle pulse when a sequence ends, on success or timeout
- sys_id, out, 32, captured ID word
- sys_timestamp, out, 32, captured timestamp word
- id_ok, out, 1, sys_id equals EXPECTED_ID
- ts_ok, out, 1, sys_timestamp equals EXPECTED_TS
- timeout_err, out, 1, the last sequence aborted on timeout

## Operation
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE: start=1, or the first post-reset cycle with AUTO_START=1, moves to ID_REQ.
  - On entry the block clears sys_id, sys_timestamp, id_ok, ts_ok and timeout_err, and loads the timeout counter.
- ID_REQ: drives av_read=1 and av_address=0.
  - Both stay stable while av_waitrequest=1.
  - The cycle with av_waitrequest=0 is the accept cycle; the next state is ID_WAIT.
- ID_WAIT: drives av_read=0.
  - On av_readdatavalid=1 the block captures av_readdata into sys_id and moves to TS_REQ.
- TS_REQ and TS_WAIT: identical to ID_REQ and ID_WAIT, with av_address=1; data is captured into sys_timestamp.
- FINISH: asserts done for one cycle, then returns to IDLE. id_ok and ts_ok hold until the next sequence begins.
- The comparisons are registered and update in the cycle after capture. Both are valid by the time done is asserted.
- Timeout handling:
  - A 16-bit down-counter loads TIMEOUT on entry to each *_REQ state and decrements every cycle in *_REQ and *_WAIT.
  - When it reaches 0 the FSM sets timeout_err=1 and goes to FINISH with av_read=0.
  - Words not yet captured stay 0, and their _ok flags stay 0.
- av_readdatavalid is ignored in IDLE, *_REQ and FINISH. Stray responses in those states are dropped.
- start while busy=1 is ignored.
- start in the FINISH cycle is also ignored; it is honoured again from IDLE.
- Reset mid-sequence drops av_read in the same cycle the reset is sampled. Any late slave response is then discarded in IDLE.
- Reset values: av_read=0, av_address=0, busy=0, done=0, sys_id=0, sys_timestamp=0, id_ok=0, ts_ok=0, timeout_err=0, state=IDLE.

## Timing
- Timing below assumes a zero-wait slave with one-cycle read latency.
- With start sampled at edge 0:
  - Cycles 1 and 2: av_read=1 and av_address=0 in cycle 1; readdatavalid in cycle 2.
  - Cycles 3 and 4: av_read=1 and av_address=1 in cycle 3; readdatavalid in cycle 4.
  - Cycle 5: done=1.
- Total latency from start to done is 5 cycles, plus one cycle for each waitrequest cycle or each extra latency cycle.
- busy=1 from cycle 1 through the done cycle inclusive.
- Outputs are all registered; there are no combinational paths from inputs to outputs.
- At most one read is outstanding; the block never pipelines reads.
- A timeout fires exactly TIMEOUT cycles after *_REQ entry if no data has been captured. done follows in the next cycle.

## Structure
- Package sysid_pkg holds:
  - the state enum;
  - the word-address constants SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - the data width constant SYSID_DW=32.
- One sub-module, sysid_rd_timer: a loadable 16-bit down-counter with a zero flag, instanced once.
- Everything else is flat in sysid_reader.

## Test plan
- Zero-wait slave returns 32'h4055_F01F for word 0 and 32'h4C61_3C0A for word 1, with the expected parameters set to those values and start at cycle 0 → done at cycle 5 with id_ok=1, ts_ok=1, timeout_err=0.
- Same slave, but EXPECTED_TS=32'h0 → done at cycle 5 with id_ok=1, ts_ok=0, and sys_timestamp=32'h4C61_3C0A.
- Slave holds waitrequest for 3 cycles on each request and uses read latency 2 → av_address and av_read are stable throughout each stall; done at cycle 5+3+1+3+1=13, with correct data.
- TIMEOUT=10, slave never asserts readdatavalid for word 1 → done 1 cycle after the count expires, timeout_err=1, sys_id captured, sys_timestamp=0, ts_ok=0.
- Reset asserted while in ID_WAIT, with readdatavalid arriving 2 cycles after reset → all outputs return to their reset values, the late data is not captured, and with AUTO_START=1 a fresh sequence runs to done.
- start pulsed during busy and again in the done cycle → only one sequence runs; a start one cycle after done launches a second sequence.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID reader.
//   sysid_state_e : read-sequence FSM states
//   SYSID_ADDR_*  : word addresses inside the system-ID slave
//   SYSID_DW      : slave data width
package sysid_pkg;

  localparam int SYSID_DW = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    FINISH  = 3'd5
  } sysid_state_e;

endpackage

// File: rtl/sysid_rd_timer.sv
// Per-transaction watchdog for the system-ID reader: a loadable 16-bit
// down-counter.
//   clock, reset : system clock, synchronous active-high reset
//   i_load       : load i_load_val (wins over i_dec)
//   i_load_val   : reload value (the transaction cycle budget)
//   i_dec        : decrement this cycle
//   o_zero       : this cycle's decrement takes the count to zero, i.e. the
//                  budget is used up at the end of the current cycle
module sysid_rd_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_dec,
  output logic        o_zero
);

  logic [15:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 16'd0)) begin
      r_count <= r_count - 16'd1;
    end
  end

  // Flag the last budgeted cycle rather than the cycle after it, so the FSM
  // can leave on the same edge the count hits zero.
  assign o_zero = i_dec && !i_load && (r_count <= 16'd1);

endmodule

// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system-ID slave's ID (word 0) and
// build timestamp (word 1), compares them against expected values and reports
// the outcome, so start-up logic can gate on the bitstream identity.
//   clock, reset          : system clock, synchronous active-high reset
//   start                 : one-cycle request to run a read sequence
//   av_address, av_read   : read request (word address, strobe)
//   av_waitrequest        : slave stall
//   av_readdata/valid     : read response
//   busy, done            : sequence in progress / one-cycle end pulse
//   sys_id, sys_timestamp : captured words (0 when not captured)
//   id_ok, ts_ok          : captured word matches its expected value
//   timeout_err           : last sequence aborted on timeout
//   dbg_state             : current FSM state
//
// Handshake: a read is accepted on a cycle with av_read=1 and
// av_waitrequest=0; av_read/av_address hold steady while stalled. The
// response is the first cycle with av_readdatavalid=1 while waiting for that
// read. Only one read is ever outstanding; responses seen in any other state
// are dropped.
module sysid_reader
  import sysid_pkg::*;
#(
  parameter logic [SYSID_DW-1:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [SYSID_DW-1:0] EXPECTED_TS = 32'h0000_0000,
  parameter int unsigned         TIMEOUT     = 255,
  parameter bit                  AUTO_START  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                av_address,
  output logic                av_read,
  input  logic                av_waitrequest,
  input  logic [SYSID_DW-1:0] av_readdata,
  input  logic                av_readdatavalid,
  output logic                busy,
  output logic                done,
  output logic [SYSID_DW-1:0] sys_id,
  output logic [SYSID_DW-1:0] sys_timestamp,
  output logic                id_ok,
  output logic                ts_ok,
  output logic                timeout_err,
  output sysid_state_e        dbg_state
);

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT);

  sysid_state_e        r_state;
  logic                r_av_read;
  logic                r_av_address;
  logic                r_busy;
  logic                r_done;
  logic [SYSID_DW-1:0] r_sys_id;
  logic [SYSID_DW-1:0] r_sys_ts;
  logic                r_id_ok;
  logic                r_ts_ok;
  logic                r_timeout_err;
  // Set while reset is held; gives exactly one automatic launch in the
  // first cycle after reset is released.
  logic                r_auto_pend;

  logic w_launch;
  logic w_tmr_load;
  logic w_tmr_dec;
  logic w_tmr_zero;

  assign w_launch   = (r_state == IDLE) && (start || r_auto_pend);
  // Reload on entry to each request state: from IDLE and on the ID capture.
  assign w_tmr_load = w_launch || ((r_state == ID_WAIT) && av_readdatavalid);
  assign w_tmr_dec  = (r_state == ID_REQ) || (r_state == ID_WAIT) ||
                      (r_state == TS_REQ) || (r_state == TS_WAIT);

  sysid_rd_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (TMO_LOAD),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_av_read     <= 1'b0;
      r_av_address  <= SYSID_ADDR_ID;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sys_id      <= '0;
      r_sys_ts      <= '0;
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_auto_pend   <= AUTO_START;
    end else begin
      r_auto_pend <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state       <= ID_REQ;
            r_av_read     <= 1'b1;
            r_av_address  <= SYSID_ADDR_ID;
            r_busy        <= 1'b1;
            r_sys_id      <= '0;
            r_sys_ts      <= '0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout_err <= 1'b0;
          end
        end
        ID_REQ: begin
          // An accept on the last budgeted cycle still counts as a timeout:
          // no data can have been captured.
          if (w_tmr_zero) begin
            r_state       <= FINISH;
            r_av_read     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
          end else if (!av_waitrequest) begin
            r_state   <= ID_WAIT;
            r_av_read <= 1'b0;
          end
        end
        ID_WAIT: begin
          // Data arriving on the last budgeted cycle is still taken.
          if (av_readdatavalid) begin
            r_sys_id     <= av_readdata;
            r_id_ok      <= (av_readdata == EXPECTED_ID);
            r_state      <= TS_REQ;
            r_av_read    <= 1'b1;
            r_av_address <= SYSID_ADDR_TS;
          end else if (w_tmr_zero) begin
            r_state       <= FINISH;
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
          end
        end
        TS_REQ: begin
          if (w_tmr_zero) begin
            r_state       <= FINISH;
            r_av_read     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
          end else if (!av_waitrequest) begin
            r_state   <= TS_WAIT;
            r_av_read <= 1'b0;
          end
        end
        TS_WAIT: begin
          if (av_readdatavalid) begin
            r_sys_ts <= av_readdata;
            r_ts_ok  <= (av_readdata == EXPECTED_TS);
            r_state  <= FINISH;
            r_done   <= 1'b1;
          end else if (w_tmr_zero) begin
            r_state       <= FINISH;
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
          end
        end
        FINISH: begin
          // start is not looked at here; it is honoured again from IDLE.
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_av_read <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign av_read       = r_av_read;
  assign av_address    = r_av_address;
  assign busy          = r_busy;
  assign done          = r_done;
  assign sys_id        = r_sys_id;
  assign sys_timestamp = r_sys_ts;
  assign id_ok         = r_id_ok;
  assign ts_ok         = r_ts_ok;
  assign timeout_err   = r_timeout_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader. Two instances share one slave model: u_dut expects
// the slave's real ID/timestamp, u_dut_ts0 expects a zero timestamp.
module tb_sysid_reader;
  import sysid_pkg::*;

  localparam logic [31:0] ID_WORD  = 32'h4055_F01F;
  localparam logic [31:0] TS_WORD  = 32'h4C61_3C0A;
  localparam logic [31:0] A_EXP_ID = ID_WORD;
  localparam logic [31:0] A_EXP_TS = TS_WORD;
  localparam logic [31:0] B_EXP_TS = 32'h0000_0000;
  localparam int          TMO      = 10;
  localparam int          EXP_W    = 100;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic start;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        av_waitrequest;
  logic        av_readdatavalid;
  logic [31:0] av_readdata;

  logic         a_av_address, a_av_read, a_busy, a_done, a_id_ok, a_ts_ok, a_tmo;
  logic [31:0]  a_sys_id, a_sys_ts;
  sysid_state_e a_state;
  logic         b_av_address, b_av_read, b_busy, b_done, b_id_ok, b_ts_ok, b_tmo;
  logic [31:0]  b_sys_id, b_sys_ts;
  sysid_state_e b_state;

  sysid_reader #(
    .EXPECTED_ID (A_EXP_ID),
    .EXPECTED_TS (A_EXP_TS),
    .TIMEOUT     (TMO),
    .AUTO_START  (1'b1)
  ) u_dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .av_address       (a_av_address),
    .av_read          (a_av_read),
    .av_waitrequest   (av_waitrequest),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .busy             (a_busy),
    .done             (a_done),
    .sys_id           (a_sys_id),
    .sys_timestamp    (a_sys_ts),
    .id_ok            (a_id_ok),
    .ts_ok            (a_ts_ok),
    .timeout_err      (a_tmo),
    .dbg_state        (a_state)
  );

  sysid_reader #(
    .EXPECTED_ID (A_EXP_ID),
    .EXPECTED_TS (B_EXP_TS),
    .TIMEOUT     (TMO),
    .AUTO_START  (1'b1)
  ) u_dut_ts0 (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .av_address       (b_av_address),
    .av_read          (b_av_read),
    .av_waitrequest   (av_waitrequest),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .busy             (b_busy),
    .done             (b_done),
    .sys_id           (b_sys_id),
    .sys_timestamp    (b_sys_ts),
    .id_ok            (b_id_ok),
    .ts_ok            (b_ts_ok),
    .timeout_err      (b_tmo),
    .dbg_state        (b_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t pend_q[$];
  int   ws_cfg  = 0;   // waitrequest cycles per request
  int   lat_cfg = 1;   // read latency after accept
  bit   drop_ts = 1'b0; // never answer word 1
  int   ws_cnt  = 0;

  initial begin
    rsp_t r;
    av_waitrequest   = 1'b0;
    av_readdatavalid = 1'b0;
    av_readdata      = '0;
    forever begin
      @(posedge clock);
      #1;
      // A response in flight across a reset comes back as junk.
      if (reset) begin
        foreach (pend_q[i]) pend_q[i].data = 32'hDEAD_BEEF;
      end
      av_readdatavalid = 1'b0;
      av_readdata      = $urandom;
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        av_readdatavalid = 1'b1;
        av_readdata      = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      av_waitrequest = 1'b0;
      if (a_av_read && !reset) begin
        if (ws_cnt < ws_cfg) begin
          av_waitrequest = 1'b1;
          ws_cnt++;
        end else begin
          ws_cnt = 0;
          if (!(a_av_address && drop_ts)) begin
            r.due  = cyc + lat_cfg;
            r.data = a_av_address ? TS_WORD : ID_WORD;
            pend_q.push_back(r);
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  // {done cycle, sys_id, sys_timestamp, id_ok, ts_ok, timeout_err, ts0 ts_ok}
  logic [EXP_W-1:0] exp_q[$];

  // Called in the cycle the launch is sampled at its end.
  task automatic push_exp();
    int          phase;
    int          lat;
    logic [31:0] ts;
    logic        ts_cap;
    logic        tmo;
    phase = ws_cfg + 1 + lat_cfg;
    if (drop_ts) begin
      lat = phase + TMO + 1;
      ts = 32'h0; ts_cap = 1'b0; tmo = 1'b1;
    end else begin
      lat = 2 * phase + 1;
      ts = TS_WORD; ts_cap = 1'b1; tmo = 1'b0;
    end
    exp_q.push_back({32'(cyc + lat), ID_WORD, ts, (ID_WORD == A_EXP_ID),
                     ts_cap && (ts == A_EXP_TS), tmo, ts_cap && (ts == B_EXP_TS)});
  endtask

  logic [EXP_W-1:0] e;
  bit   after_done = 1'b0;
  bit   prev_stall = 1'b0;
  logic prev_addr  = 1'b0;

  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (prev_stall) begin
        check("stall_read", a_av_read, 1);
        check("stall_addr", a_av_address, prev_addr);
      end
      prev_stall = a_av_read && av_waitrequest;
      prev_addr  = a_av_address;

      if (after_done) begin
        check("busy_after_done", a_busy, 0);
        check("done_width", a_done, 0);
        after_done = 1'b0;
      end else if (a_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", a_done, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e[99:68]);
          check("sys_id", a_sys_id, e[67:36]);
          check("sys_timestamp", a_sys_ts, e[35:4]);
          check("id_ok", a_id_ok, e[3]);
          check("ts_ok", a_ts_ok, e[2]);
          check("timeout_err", a_tmo, e[1]);
          check("busy_at_done", a_busy, 1);
          check("ts0_done", b_done, 1);
          check("ts0_sys_id", b_sys_id, e[67:36]);
          check("ts0_sys_timestamp", b_sys_ts, e[35:4]);
          check("ts0_id_ok", b_id_ok, e[3]);
          check("ts0_ts_ok", b_ts_ok, e[0]);
          check("ts0_timeout_err", b_tmo, e[1]);
          after_done = 1'b1;
        end
      end else if (exp_q.size() != 0 && cyc > int'(exp_q[0][99:68])) begin
        e = exp_q.pop_front();
        check("done_missing", cyc, e[99:68]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    push_exp();
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("wait_bound", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_av_read"}, a_av_read, 0);
    check({tag, "_av_address"}, a_av_address, 0);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_sys_id"}, a_sys_id, 0);
    check({tag, "_sys_timestamp"}, a_sys_ts, 0);
    check({tag, "_id_ok"}, a_id_ok, 0);
    check({tag, "_ts_ok"}, a_ts_ok, 0);
    check({tag, "_timeout_err"}, a_tmo, 0);
    check({tag, "_state"}, 32'(a_state), 32'(IDLE));
    check({tag, "_ts0_busy"}, b_busy, 0);
    check({tag, "_ts0_av_read"}, b_av_read, 0);
    check({tag, "_ts0_av_address"}, b_av_address, 0);
    check({tag, "_ts0_state"}, 32'(b_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("por");

    // Auto-start: the first cycle after release launches a sequence.
    push_exp();
    reset = 1'b0;
    wait_quiet();

    // Zero-wait slave, explicit start.
    pulse_start();
    wait_quiet();

    // Three stall cycles per request, read latency 2.
    ws_cfg = 3; lat_cfg = 2;
    pulse_start();
    wait_quiet();
    ws_cfg = 0; lat_cfg = 1;

    // Word 1 never answered: timeout.
    drop_ts = 1'b1;
    pulse_start();
    wait_quiet();
    drop_ts = 1'b0;

    // start while busy and in the done cycle is ignored; the next cycle is not.
    n0 = cyc;
    pulse_start();
    repeat ($urandom_range(0, 2)) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (cyc < n0 + 5) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    push_exp();
    @(negedge clock);
    start = 1'b0;
    wait_quiet();

    // Reset in ID_WAIT; the in-flight response lands after release.
    lat_cfg = 3;
    pulse_start();
    @(negedge clock);
    check("pre_reset_state", 32'(a_state), 32'(ID_WAIT));
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check_reset_vals("mid_seq");
    push_exp();
    reset = 1'b0;
    wait_quiet();
    lat_cfg = 1;

    // A few random slave timings.
    for (int i = 0; i < 3; i++) begin
      ws_cfg  = $urandom_range(0, 2);
      lat_cfg = $urandom_range(1, 3);
      pulse_start();
      wait_quiet();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
